// File: rtl/sprite_pkg.sv
// Shared types and raster constants for the sprite renderer.
package sprite_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = $clog2(H_ACTIVE);

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Frame boundary: first pixel of the first line below the active area.
    function automatic logic is_fb(input coord_t x, input coord_t y);
        return (x == '0) && (y == coord_t'(V_ACTIVE));
    endfunction

endpackage

// File: rtl/sprite_palette_ram.sv
// Palette register file: one synchronous write port, one combinational read port.
// A write and a read of the same entry in one cycle returns the old contents.
module sprite_palette_ram
    import sprite_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  rgb12_t           wdata,
    input  logic [IDX_W-1:0] raddr,
    output rgb12_t           rdata
);

    rgb12_t mem [2**IDX_W];

    // Palette write port; all entries clear to black on reset.
    // NOTE: this is a small flop array, not a RAM macro, so resetting every entry is legal and keeps the first frame deterministic.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_renderer.sv
// Palettized, animated, scalable sprite over a background colour.
// Pipeline: stage 0 box test (comb), stage 1 ROM address, stage 2 ROM data,
// then the registered colour output -- three cycles from DrawX/DrawY to red/green/blue.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int N_FRAMES   = 4,
    parameter int SCALE_LOG2 = 0,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8,
    parameter int ADDR_W     = $clog2(SPR_W*SPR_H*N_FRAMES),
    localparam int FRAME_W   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic              anim_en,
    input  logic [FRAME_W-1:0] frame_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [11:0]       pal_wdata,
    input  logic [11:0]       bg_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit
);

    localparam int BOX_W      = SPR_W << SCALE_LOG2;
    localparam int BOX_H      = SPR_H << SCALE_LOG2;
    localparam int FRAME_SIZE = SPR_W * SPR_H;
    localparam int CNT_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [FRAME_W:0] N_FRAMES_W = (FRAME_W+1)'(N_FRAMES);

    coord_t              act_x, act_y, sh_x, sh_y;
    logic                sh_full;
    logic [FRAME_W-1:0]  frame;
    logic [CNT_W-1:0]    anim_cnt;
    logic                fb, pos_load;

    assign fb        = is_fb(DrawX, DrawY);
    assign pos_ready = !sh_full;
    assign pos_load  = pos_valid && !sh_full;

    // Double-buffered position: park offers in the shadow, commit them at the frame boundary.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            act_x   <= '0;
            act_y   <= '0;
            sh_x    <= '0;
            sh_y    <= '0;
            sh_full <= 1'b0;
        end else if (fb) begin
            if (sh_full) begin
                act_x   <= sh_x;
                act_y   <= sh_y;
                sh_full <= 1'b0;
            end else if (pos_load) begin
                act_x <= pos_x;
                act_y <= pos_y;
            end
        end else if (pos_load) begin
            sh_x    <= pos_x;
            sh_y    <= pos_y;
            sh_full <= 1'b1;
        end
    end

    // Animation frame select, updated only at the frame boundary.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame    <= '0;
            anim_cnt <= '0;
        end else if (fb) begin
            if (anim_en) begin
                if (anim_cnt == CNT_W'(ANIM_DIV-1)) begin
                    anim_cnt <= '0;
                    frame    <= (frame == FRAME_W'(N_FRAMES-1)) ? '0 : frame + 1'b1;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end else if ({1'b0, frame_sel} < N_FRAMES_W) begin
                frame <= frame_sel;
            end
        end
    end

    // Stage 0: screen position relative to the sprite; bit 10 is the borrow.
    logic [10:0]       rel_x, rel_y, tex_x, tex_y;
    logic              inbox;
    logic [ADDR_W-1:0] addr_next;

    assign rel_x = {1'b0, DrawX} - {1'b0, act_x};
    assign rel_y = {1'b0, DrawY} - {1'b0, act_y};
    assign inbox = !rel_x[10] && !rel_y[10]
                && (rel_x < 11'(BOX_W)) && (rel_y < 11'(BOX_H));
    assign tex_x = rel_x >> SCALE_LOG2;
    assign tex_y = rel_y >> SCALE_LOG2;
    assign addr_next = ADDR_W'(frame) * ADDR_W'(FRAME_SIZE)
                     + ADDR_W'(tex_y) * ADDR_W'(SPR_W)
                     + ADDR_W'(tex_x);

    logic   inbox_d1, blank_d1, inbox_d2, blank_d2;
    rgb12_t bg_d1, bg_d2;

    // Stages 1 and 2: ROM address (held outside the box) and the side-band delay line.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            inbox_d1 <= 1'b0;
            blank_d1 <= 1'b0;
            bg_d1    <= '0;
            inbox_d2 <= 1'b0;
            blank_d2 <= 1'b0;
            bg_d2    <= '0;
        end else begin
            if (inbox) rom_addr <= addr_next;
            inbox_d1 <= inbox;
            blank_d1 <= blank;
            bg_d1    <= bg_rgb;
            inbox_d2 <= inbox_d1;
            blank_d2 <= blank_d1;
            bg_d2    <= bg_d1;
        end
    end

    rgb12_t pal_rgb;

    sprite_palette_ram #(.IDX_W(IDX_W)) u_palette (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .we      (pal_we),
        .waddr   (pal_waddr),
        .wdata   (pal_wdata),
        .raddr   (rom_q),
        .rdata   (pal_rgb)
    );

    // Output colour: black in blanking, palette colour on opaque texels, else background.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            {red, green, blue} <= '0;
            hit                <= 1'b0;
        end else if (!blank_d2) begin
            {red, green, blue} <= '0;
            hit                <= 1'b0;
        end else if (inbox_d2 && (rom_q != IDX_W'(TRANSP_IDX))) begin
            {red, green, blue} <= {pal_rgb.r, pal_rgb.g, pal_rgb.b};
            hit                <= 1'b1;
        end else begin
            {red, green, blue} <= {bg_d2.r, bg_d2.g, bg_d2.b};
            hit                <= 1'b0;
        end
    end

endmodule
